// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: line state encoding, default baud
//            divisor and frame-length helpers. Used by uart_tx and uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Line state shared by transmitter and receiver
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // 100 MHz system clock at 115200 baud
    localparam int C_DEFAULT_CLKS_PER_BIT = 868;
    localparam int C_START_BITS           = 1;

    // Number of bit periods in one frame on the line
    function automatic int frame_bits(input int width, input int stop_bits,
                                      input bit parity);
        return C_START_BITS + width + (parity ? 1 : 0) + stop_bits;
    endfunction

    // Clocks from one pop to the next with a continuously non-empty FIFO
    // (one idle cycle separates frames)
    function automatic int frame_period_clks(input int width, input int stop_bits,
                                             input int clks_per_bit, input bit parity);
        return frame_bits(width, stop_bits, parity) * clks_per_bit + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last
//            clock of each bit. Held at zero while clear is high so the first
//            bit after a clear lasts a full period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int                 C_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);

    logic [C_CNT_W-1:0] r_baud_cnt;

    assign bit_end = (r_baud_cnt == C_LAST);

    // Bit counter: restarts on clear or at the end of every bit, never wraps on its own
    always_ff @(posedge clk) begin
        if (rst_n || clear || bit_end) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter fed directly by a TX FIFO. Pops one word when
//            idle and the FIFO is non-empty, then sends start bit, data LSB
//            first, optional even parity, and STOP_BITS stop bits.
//            Define UART_TX_PARITY_EN to insert the even-parity bit.
//            Note: rst_n is active-high (1 = reset) despite its name.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int                 C_IDX_W     = $clog2(WIDTH);
    localparam logic [C_IDX_W-1:0] C_LAST_DATA = C_IDX_W'(WIDTH - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_STOP = C_IDX_W'(STOP_BITS - 1);

    uart_state_e        r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [C_IDX_W-1:0] r_bit_idx;
    logic               r_tx;
    logic               r_busy;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic w_bit_end;
    logic w_baud_clear;
    logic w_pop;

    // Pop is decoded combinationally so the FIFO head is consumed in the same cycle it is latched
    assign w_pop        = (r_state == ST_IDLE) && !fifo_empty && !rst_n;
    // Timer held at zero while idle so START gets a full bit period
    assign w_baud_clear = (r_state == ST_IDLE);

    assign fifo_pop   = w_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = (r_state == ST_STOP) && w_bit_end && (r_bit_idx == C_LAST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_baud_clear),
        .bit_end (w_bit_end)
    );

    // Frame sequencer; tx is loaded one edge ahead so it changes exactly on bit boundaries
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= fifo_data;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                        r_bit_idx <= '0;
                        r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^fifo_data;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == C_LAST_DATA) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= ST_PARITY;
`else
                            r_tx      <= 1'b1;
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == C_LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx (WIDTH=8, CLKS_PER_BIT=4,
//            STOP_BITS=1). Stimulus queues bytes into a FIFO model and pushes
//            hand-computed line patterns; a monitor rebuilds each frame.
//            Works with or without UART_TX_PARITY_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int NBITS = 11;
`else
    localparam bit PAR   = 1'b0;
    localparam int NBITS = 10;
`endif
    localparam int GAP = NBITS * CPB + 1;

    typedef struct packed {
        logic [7:0]  data;
        logic [10:0] pat;   // line value per bit period, bit 0 = start bit
        logic        abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [16];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         cyc = 0;

    exp_t exp_q[$];
    int   pop_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;
    bit   mon_active = 1'b0;

    uart_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = (rd_ptr == wr_ptr);
        fifo_data  = mem[rd_ptr[3:0]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
    end

    always @(negedge clk) begin
        if (fifo_pop === 1'b1 && (fifo_empty || rst_n || busy)) viol++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    function automatic logic [10:0] pick(input logic [10:0] plain, input logic [10:0] with_par);
        return PAR ? with_par : plain;
    endfunction

    task automatic send(input logic [7:0] d, input logic [10:0] pat, input logic abort);
        exp_q.push_back('{data: d, pat: pat, abort: abort});
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!mon_active && exp_q.size() == 0 && !busy && fifo_empty) break;
            n++;
            if (n >= bound) begin
                checks++; errors++;
                $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_pop(input int bound);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (fifo_pop) break;
            n++;
            if (n >= bound) begin
                checks++; errors++;
                $display("FAIL wait_pop: got timeout after %0d cycles expected pop", n);
                break;
            end
        end
    endtask

    // Monitor: on each pop, take the next expectation and rebuild the frame
    initial begin : monitor
        exp_t        e;
        logic [10:0] got;
        bit          stable, fd_ok, busy_ok, aborted;
        @(negedge clk);
        forever begin
            if (fifo_pop === 1'b1) begin
                mon_active = 1'b1;
                pop_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pop: got pop of 0x%0h expected none", fifo_data);
                    e = '{data: fifo_data, pat: 11'h0, abort: 1'b0};
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(fifo_data), 32'(e.data));
                end
                got = '0; stable = 1'b1; fd_ok = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
                for (int b = 0; b < NBITS && !aborted; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (rst_n) begin aborted = 1'b1; break; end
                        if (c == 0) got[b] = tx;
                        else if (tx !== got[b]) stable = 1'b0;
                        if (frame_done !== ((b == NBITS-1) && (c == CPB-1))) fd_ok = 1'b0;
                        if (busy !== 1'b1) busy_ok = 1'b0;
                    end
                end
                chk("abort_flag", 32'(aborted), 32'(e.abort));
                if (!aborted) begin
                    @(negedge clk);
                    if (busy !== 1'b0 || frame_done !== 1'b0) busy_ok = 1'b0;
                    chk("frame_bits", {20'h0, stable, got}, {20'h0, 1'b1, e.pat});
                    chk("frame_done_timing", 32'(fd_ok), 32'd1);
                    chk("busy_window", 32'(busy_ok), 32'd1);
                end
                mon_active = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n0;
        int bad;
        rst_n = 1'b1;
        // Word waiting during reset must not be popped until release
        send(8'h81, pick(11'h302, 11'h502), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_tx", 32'(tx), 32'd1);
            chk("reset_pop", 32'(fifo_pop), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1; rst_n = 1'b0;
        wait_idle(200);

        // Single byte
        @(posedge clk); #1;
        send(8'hA5, pick(11'h34A, 11'h54A), 1'b0);
        wait_idle(200);

        // Back-to-back frames
        n0 = pop_cycles.size();
        @(posedge clk); #1;
        send(8'h00, pick(11'h200, 11'h400), 1'b0);
        send(8'hFF, pick(11'h3FE, 11'h5FE), 1'b0);
        wait_idle(300);
        chk("b2b_pop_count", 32'(pop_cycles.size() - n0), 32'd2);
        if (pop_cycles.size() >= n0 + 2)
            chk("b2b_pop_gap", 32'(pop_cycles[n0+1] - pop_cycles[n0]), 32'(GAP));

        // Empty FIFO stays quiet
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) bad++;
        end
        chk("empty_quiet", 32'(bad), 32'd0);

        // Reset during DATA bit 3 of 0x3C
        @(posedge clk); #1;
        send(8'h3C, 11'h0, 1'b1);
        wait_pop(200);
        repeat (17) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
        send(8'hC3, pick(11'h386, 11'h586), 1'b0);
        @(negedge clk);
        chk("abort_pop_gated", 32'(fifo_pop), 32'd0);
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pop", 32'(fifo_pop), 32'd0);
        @(posedge clk); #1; rst_n = 1'b0;
        wait_idle(200);

`ifdef UART_TX_PARITY_EN
        @(posedge clk); #1;
        send(8'h07, 11'h60E, 1'b0);
        wait_idle(200);
        @(posedge clk); #1;
        send(8'h03, 11'h406, 1'b0);
        wait_idle(200);
`endif

        chk("pop_protocol", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
